lsq_tag_queue: RTL and testbench
================================

# lsq_tag_queue

Parametrised in-order tag queue for the load/store unit. It records the reservation-station tags of memory operations in issue order and presents the oldest one to the address-calculation stage. It generalises the fixed 4-bit queue with:
- a configurable tag width and depth,
- valid/ready handshakes on both sides,
- an occupancy count,
- a synchronous flush for branch-mispredict recovery,
- an optional duplicate-tag guard.

It sits between issue (enqueue) and the address unit (dequeue).

## Interface
- TAG_W, 4, tag width in bits (≥1)
- DEPTH, 8, number of entries; must be a power of two, ≥2
- CNT_W (localparam), $clog2(DEPTH)+1, width of the occupancy count
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous queue clear; highest priority
- enq_valid  input  1  issue presents a tag
- enq_ready  output  1  queue accepts the tag this cycle
- enq_tag  input  TAG_W  tag to enqueue
- deq_valid  output  1  head entry is valid
- deq_ready  input  1  address unit consumes the head
- deq_tag  output  TAG_W  oldest tag; 0 when deq_valid=0
- count  output  CNT_W  number of valid entries, 0..DEPTH
- full  output  1  count==DEPTH
- empty  output  1  count==0
- dup_err  output  1  sticky duplicate-tag flag; constant 0 when the guard is compiled out

## Operation
- Storage is a circular buffer of DEPTH×TAG_W registers with rd_ptr and wr_ptr, each log2(DEPTH) bits, plus the count register.
- Pointers wrap naturally modulo DEPTH.
- Handshake:
  - enq_fire = enq_valid & enq_ready.
  - deq_fire = deq_valid & deq_ready.
- enq_ready = !full, further qualified by the duplicate guard when it is enabled.
- enq_ready never depends on deq_ready. A full queue therefore rejects an enqueue even when a dequeue occurs in the same cycle.
- deq_valid = !empty.
- deq_tag = mem[rd_ptr] when !empty, else 0. The output is first-word fall-through and combinational from registers.
- enq_fire: mem[wr_ptr] ← enq_tag; wr_ptr increments.
- deq_fire: rd_ptr increments.
- Count update:
  - count increases by 1 on enq_fire only.
  - count decreases by 1 on deq_fire only.
  - count is unchanged when both fire together.
  - Simultaneous enqueue and dequeue is legal at any occupancy 1..DEPTH-1.
- flush=1: rd_ptr, wr_ptr and count all become 0 and dup_err clears.
  - Any enq_fire or deq_fire in the same cycle is ignored.
  - Memory contents are not cleared.
- Tag values, including 0, carry no meaning to the queue apart from the duplicate guard.

## Timing
- Reset (rst=0, asynchronous) values:
  - count=0, empty=1, full=0, enq_ready=1
  - deq_valid=0, deq_tag=0, dup_err=0
  - pointers 0
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Enqueue-to-dequeue latency is 1 cycle. A tag accepted at edge t is visible on deq_tag/deq_valid after edge t, with no bypass on an empty queue.
- count, full and empty update on the same edge as the fire that changes them.
- Dequeue at count=1 with no enqueue: deq_valid=0 and deq_tag=0 after the edge.
- Flush takes effect at the edge where flush=1 is sampled. Enqueues are accepted again in the next cycle.

## Configuration
- Macro: LSQ_DUP_CHECK_EN.
- Defined:
  - dup_hit = enq_valid, AND enq_tag equals the tag of any currently valid entry, compared against the state at the start of the cycle.
  - A head being dequeued in the same cycle still counts as a match.
  - enq_ready = !full & !dup_hit, so the duplicate tag is not written.
  - dup_err sets at the edge after a dup_hit and stays 1 until reset or flush.
- Not defined:
  - No comparators are built.
  - enq_ready = !full.
  - dup_err is tied to 0.
  - Duplicate tags are stored like any other tag.

## Test plan
- Reset, then enqueue tags 3, 7, 1 on consecutive cycles with deq_ready=0. Required: count=3 and deq_tag=3. Then hold deq_ready=1; dequeue order is 3, 7, 1, followed by empty=1 and deq_tag=0.
- Fill DEPTH=8 with tags 0..7. Required: full=1 and enq_ready=0. Then assert enq_valid and deq_ready in the same cycle; the head pops, the enqueue is rejected, and count=7.
- At count=4, hold enq_valid and deq_ready for 20 cycles with incrementing tags. Required: count stays 4, pointers wrap, and FIFO order is preserved.
- Queue holds 3 entries; assert flush together with enq_valid=1 and deq_ready=1. Required next cycle: count=0, empty=1, deq_valid=0, and the flush-cycle enqueue is absent.
- With LSQ_DUP_CHECK_EN, queue holds tags 5 and 9; present enq_tag=9. Required: enq_ready=0, count stays 2, and dup_err=1 until flush. Without the macro, the same stimulus gives count=3 and dup_err=0.
- Assert rst=0 asynchronously between edges while count=5. Required: outputs go to reset values immediately, and count=0 after rst is released.

Source files
------------

// File: rtl/lsq_tag_queue_if.sv
// lsq_tag_queue_if: bundles the issue-side, address-unit-side and status
// signals of the LSU tag queue.
// Ports: flush, enq_valid/enq_ready/enq_tag, deq_valid/deq_ready/deq_tag,
//        count, full, empty, dup_err. slave = queue side, master = its user.
interface lsq_tag_queue_if #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [TAG_W-1:0] enq_tag;
  logic             deq_valid;
  logic             deq_ready;
  logic [TAG_W-1:0] deq_tag;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             dup_err;

  modport slave (
    input  flush, enq_valid, enq_tag, deq_ready,
    output enq_ready, deq_valid, deq_tag, count, full, empty, dup_err
  );

  modport master (
    output flush, enq_valid, enq_tag, deq_ready,
    input  enq_ready, deq_valid, deq_tag, count, full, empty, dup_err
  );
endinterface

// File: rtl/lsq_tag_queue.sv
// lsq_tag_queue: in-order circular queue of reservation-station tags, oldest
//   presented first-word fall-through to the address unit. Latency 1 cycle
//   (enqueue at edge t visible after edge t, no empty bypass).
// Backpressure: enq_ready = !full (and !dup_hit with LSQ_DUP_CHECK_EN); it
//   never looks at deq_ready, so a full queue refuses even while popping.
// Ports: clk, rst (async active-low), q (lsq_tag_queue_if.slave).
// Optional macro LSQ_DUP_CHECK_EN: refuse a tag already held in the queue
//   and raise sticky dup_err; otherwise dup_err is tied low.
module lsq_tag_queue #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  lsq_tag_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, enq_fire, deq_fire, enq_rdy;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

`ifdef LSQ_DUP_CHECK_EN
  logic dup_hit;
  logic dup_err_q, dup_err_d;

  // Compare against every occupied slot as of the start of the cycle; a head
  // being popped this same cycle still counts as present.
  always_comb begin
    dup_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (mem_q[rd_ptr_q + PTR_W'(k)] == q.enq_tag))
        dup_hit = 1'b1;
    end
    dup_hit = dup_hit & q.enq_valid;
  end

  assign enq_rdy   = !full && !dup_hit;
  assign dup_err_d = q.flush ? 1'b0 : (dup_err_q | dup_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dup_err_q <= 1'b0;
    else      dup_err_q <= dup_err_d;
  end

  assign q.dup_err = dup_err_q;
`else
  assign enq_rdy   = !full;
  assign q.dup_err = 1'b0;
`endif

  assign enq_fire = q.enq_valid && enq_rdy;
  assign deq_fire = !empty && q.deq_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (enq_fire && !deq_fire)      count_d = count_q + CNT_W'(1);
      else if (!enq_fire && deq_fire) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (enq_fire && !q.flush) mem_q[wr_ptr_q] <= q.enq_tag;
  end

  assign q.enq_ready = enq_rdy;
  assign q.deq_valid = !empty;
  assign q.deq_tag   = empty ? '0 : mem_q[rd_ptr_q];
  assign q.count     = count_q;
  assign q.full      = full;
  assign q.empty     = empty;
endmodule

// File: tb/tb_lsq_tag_queue.sv
module tb_lsq_tag_queue;
  localparam int TAG_W = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsq_tag_queue_if #(.TAG_W(TAG_W), .DEPTH(DEPTH)) qif ();

  lsq_tag_queue #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [TAG_W-1:0] sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [TAG_W-1:0] tag, input logic dr, input logic fl);
    qif.enq_valid = ev;
    qif.enq_tag   = tag;
    qif.deq_ready = dr;
    qif.flush     = fl;
  endtask

  // Accepted enqueue: expected tag goes to the scoreboard.
  task automatic enq(input logic [TAG_W-1:0] tag, input logic dr);
    drive(1'b1, tag, dr, 1'b0);
    sbq.push_back(tag);
    tick();
  endtask

  // Monitor: every dequeue handshake pops the oldest expected tag.
  always @(negedge clk) begin
    if (rst && !qif.flush && qif.deq_valid && qif.deq_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_pop", 32'(qif.deq_tag), 32'hFFFF_FFFF);
      end else begin
        check("deq_order", 32'(qif.deq_tag), 32'(sbq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    // Reset values while rst is held low.
    check("rst_count",     32'(qif.count),     0);
    check("rst_empty",     32'(qif.empty),     1);
    check("rst_full",      32'(qif.full),      0);
    check("rst_enq_ready", 32'(qif.enq_ready), 1);
    check("rst_deq_valid", 32'(qif.deq_valid), 0);
    check("rst_deq_tag",   32'(qif.deq_tag),   0);
    check("rst_dup_err",   32'(qif.dup_err),   0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1) enqueue 3,7,1, no bypass on empty queue, then drain in order.
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    sbq.push_back(4'd3);
    #1 check("no_bypass", 32'(qif.deq_valid), 0);
    tick();
    check("lat1_valid", 32'(qif.deq_valid), 1);
    check("lat1_tag",   32'(qif.deq_tag),   3);
    enq(4'd7, 1'b0);
    enq(4'd1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t1_count", 32'(qif.count),   3);
    check("t1_head",  32'(qif.deq_tag), 3);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) tick();
    check("t1_empty",   32'(qif.empty),     1);
    check("t1_deqtag0", 32'(qif.deq_tag),   0);
    check("t1_deqv0",   32'(qif.deq_valid), 0);

    // 2) fill with 0..7, then enqueue+dequeue together on a full queue.
    for (int i = 0; i < DEPTH; i++) enq(TAG_W'(i), 1'b0);
    drive(1'b1, 4'd9, 1'b1, 1'b0);
    #1;
    check("t2_full",      32'(qif.full),      1);
    check("t2_enq_ready", 32'(qif.enq_ready), 0);
    check("t2_count8",    32'(qif.count),     8);
    tick();
    check("t2_count7", 32'(qif.count), 7);
    check("t2_nofull", 32'(qif.full),  0);
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (7) tick();
    check("t2_empty", 32'(qif.empty), 1);

    // 3) steady state at count=4 for 20 cycles, pointers wrap.
    for (int i = 0; i < 4; i++) enq(TAG_W'(10 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      enq(TAG_W'(14 + i), 1'b1);
      check("t3_count4", 32'(qif.count), 4);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();
    check("t3_empty", 32'(qif.empty), 1);

    // 4) flush beats a same-cycle enqueue and dequeue.
    drive(1'b0, '0, 1'b0, 1'b0);
    enq(4'd2, 1'b0);
    enq(4'd4, 1'b0);
    enq(4'd6, 1'b0);
    drive(1'b1, 4'd8, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    sbq.delete();
    check("t4_count",   32'(qif.count),     0);
    check("t4_empty",   32'(qif.empty),     1);
    check("t4_deqv",    32'(qif.deq_valid), 0);
    check("t4_deqtag",  32'(qif.deq_tag),   0);
    check("t4_enq_rdy", 32'(qif.enq_ready), 1);
    enq(4'd8, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("t4_refill_drained", 32'(qif.empty), 1);

    // 5) duplicate tag 9 with 5,9 held.
    drive(1'b0, '0, 1'b0, 1'b0);
    enq(4'd5, 1'b0);
    enq(4'd9, 1'b0);
    drive(1'b1, 4'd9, 1'b0, 1'b0);
    #1;
`ifdef LSQ_DUP_CHECK_EN
    check("t5_enq_ready", 32'(qif.enq_ready), 0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t5_count",   32'(qif.count),   2);
    check("t5_dup_err", 32'(qif.dup_err), 1);
    tick();
    check("t5_dup_sticky", 32'(qif.dup_err), 1);
`else
    check("t5_enq_ready", 32'(qif.enq_ready), 1);
    sbq.push_back(4'd9);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t5_count",   32'(qif.count),   3);
    check("t5_dup_err", 32'(qif.dup_err), 0);
`endif
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    sbq.delete();
    check("t5_flush_dup", 32'(qif.dup_err), 0);
    check("t5_flush_cnt", 32'(qif.count),   0);

    // 6) asynchronous reset between edges at count=5.
    for (int i = 1; i <= 5; i++) enq(TAG_W'(i), 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t6_count5", 32'(qif.count), 5);
    #2 rst = 1'b0;
    #1;
    sbq.delete();
    check("t6_count",   32'(qif.count),     0);
    check("t6_empty",   32'(qif.empty),     1);
    check("t6_full",    32'(qif.full),      0);
    check("t6_enq_rdy", 32'(qif.enq_ready), 1);
    check("t6_deqv",    32'(qif.deq_valid), 0);
    check("t6_deqtag",  32'(qif.deq_tag),   0);
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    check("t6_post_count", 32'(qif.count), 0);
    enq(4'd7, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t6_post_empty", 32'(qif.empty), 1);

    check("scoreboard_drained", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
